// File: rtl/led_sched.sv
// led_sched: arbitrates host and alarm updates of the 8 x 4-bit LED mode word and paces commits.
// Optional LED0 heartbeat is built when LED_SCHED_HEARTBEAT_EN is defined.
module led_sched #(
    parameter int HOLD_CYC  = 64,
    parameter int HB_PERIOD = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        host_req,
    input  logic [7:0]  host_mask,
    input  logic [31:0] host_mode,
    output logic        host_ack,
    input  logic        alm_req,
    input  logic [7:0]  alm_mask,
    input  logic [31:0] alm_mode,
    output logic        alm_ack,
    input  logic        alm_clr,
    output logic [31:0] led_din,
    output logic        led_vld,
    output logic        busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_COMMIT = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;
    localparam int         CNT_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    if (HOLD_CYC < 1) begin : g_chk_hold
        $error("led_sched: HOLD_CYC must be at least 1");
    end
    if (HB_PERIOD < 2) begin : g_chk_hb
        $error("led_sched: HB_PERIOD must be at least 2");
    end

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_host_shadow;
    logic [31:0]      r_alm_val;
    logic [7:0]       r_alm_own;
    logic             r_clr_pend;
    logic [31:0]      r_led_din;
    logic             r_led_vld;
    logic             r_host_ack;
    logic             r_alm_ack;

    logic        w_arb;
    logic        w_clr_now;
    logic        w_host_eff;
    logic        w_alm_eff;
    logic        w_sel_clr;
    logic        w_sel_alm;
    logic        w_sel_host;
    logic        w_sel_hb;
    logic        w_any;
    logic [7:0]  w_host_mask;
    logic [31:0] w_nxt_host;
    logic [31:0] w_nxt_val;
    logic [7:0]  w_nxt_own;
    logic [31:0] w_disp;

    function automatic logic [31:0] nib_expand(input logic [7:0] m);
        logic [31:0] x;
        x = '0;
        for (int i = 0; i < 8; i++) begin
            x[4*i +: 4] = {4{m[i]}};
        end
        return x;
    endfunction

`ifdef LED_SCHED_HEARTBEAT_EN
    localparam int HB_W = $clog2(HB_PERIOD);

    logic [HB_W-1:0] r_hb_cnt;
    logic            r_hb_state;
    logic            r_hb_pend;
    logic            w_hb_tick;

    assign w_hb_tick   = (r_hb_cnt == HB_W'(HB_PERIOD - 1));
    assign w_host_mask = {host_mask[7:1], 1'b0};

    // A toggle that finds the previous heartbeat still pending simply overwrites it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hb_cnt   <= '0;
            r_hb_state <= 1'b0;
            r_hb_pend  <= 1'b0;
        end else begin
            r_hb_cnt <= w_hb_tick ? '0 : r_hb_cnt + 1'b1;
            if (w_hb_tick) begin
                r_hb_state <= ~r_hb_state;
                r_hb_pend  <= 1'b1;
            end else if (w_sel_hb) begin
                r_hb_pend <= 1'b0;
            end
        end
    end
`else
    assign w_host_mask = host_mask;
`endif

    // Arbitration also runs in the last HOLD cycle so back-to-back commits land HOLD_CYC+1 apart.
    always_comb begin
        w_arb      = (r_state == S_IDLE) || ((r_state == S_HOLD) && (r_cnt == '0));
        w_clr_now  = r_clr_pend | alm_clr;
        w_alm_eff  = alm_req & ~r_alm_ack;
        w_host_eff = host_req & ~r_host_ack;
        w_sel_clr  = 1'b0;
        w_sel_alm  = 1'b0;
        w_sel_host = 1'b0;
        w_sel_hb   = 1'b0;
        w_nxt_host = r_host_shadow;
        w_nxt_val  = r_alm_val;
        w_nxt_own  = r_alm_own;
        if (w_arb) begin
            if (w_clr_now) begin
                w_sel_clr = 1'b1;
                w_nxt_own = '0;
            end else if (w_alm_eff) begin
                w_sel_alm = 1'b1;
                w_nxt_own = r_alm_own | alm_mask;
                w_nxt_val = (r_alm_val & ~nib_expand(alm_mask)) | (alm_mode & nib_expand(alm_mask));
            end else if (w_host_eff) begin
                w_sel_host = 1'b1;
                w_nxt_host = (r_host_shadow & ~nib_expand(w_host_mask))
                           | (host_mode & nib_expand(w_host_mask));
            end
`ifdef LED_SCHED_HEARTBEAT_EN
            else if (r_hb_pend) begin
                w_sel_hb        = 1'b1;
                w_nxt_host[3:0] = {3'b000, r_hb_state};
            end
`endif
        end
        w_any  = w_sel_clr | w_sel_alm | w_sel_host | w_sel_hb;
        w_disp = (w_nxt_val & nib_expand(w_nxt_own)) | (w_nxt_host & ~nib_expand(w_nxt_own));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_host_shadow <= '0;
            r_alm_val     <= '0;
            r_alm_own     <= '0;
            r_clr_pend    <= 1'b0;
            r_led_din     <= '0;
            r_led_vld     <= 1'b0;
            r_host_ack    <= 1'b0;
            r_alm_ack     <= 1'b0;
        end else begin
            r_led_vld  <= 1'b0;
            r_host_ack <= 1'b0;
            r_alm_ack  <= 1'b0;

            if (w_sel_clr) begin
                r_clr_pend <= 1'b0;
            end else if (alm_clr) begin
                r_clr_pend <= 1'b1;
            end

            if (w_any) begin
                r_host_shadow <= w_nxt_host;
                r_alm_val     <= w_nxt_val;
                r_alm_own     <= w_nxt_own;
                r_host_ack    <= w_sel_host;
                r_alm_ack     <= w_sel_alm;
                if (w_disp != r_led_din) begin
                    r_led_din <= w_disp;
                    r_led_vld <= 1'b1;
                    r_state   <= S_COMMIT;
                end else begin
                    r_state <= S_IDLE;
                end
            end else begin
                case (r_state)
                    S_COMMIT: begin
                        r_state <= S_HOLD;
                        r_cnt   <= CNT_W'(HOLD_CYC - 1);
                    end
                    S_HOLD: begin
                        if (r_cnt == '0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign host_ack = r_host_ack;
    assign alm_ack  = r_alm_ack;
    assign led_din  = r_led_din;
    assign led_vld  = r_led_vld;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_led_sched.sv
// tb_led_sched: directed and randomized checks of led_sched against a nibble-array reference model.
module tb_led_sched;

    localparam int H     = 8;
    localparam int HB    = 16;
    localparam int BOUND = 4 * H + 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_req = 1'b0;
    logic [7:0]  host_mask = '0;
    logic [31:0] host_mode = '0;
    logic        host_ack;
    logic        alm_req = 1'b0;
    logic [7:0]  alm_mask = '0;
    logic [31:0] alm_mode = '0;
    logic        alm_ack;
    logic        alm_clr = 1'b0;
    logic [31:0] led_din;
    logic        led_vld;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int cycleCount = 0;

    int          hostNib[8];
    int          almNib[8];
    bit          owned[8];
    logic [31:0] modelLed;

    led_sched #(.HOLD_CYC(H), .HB_PERIOD(HB)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_req(host_req), .host_mask(host_mask), .host_mode(host_mode), .host_ack(host_ack),
        .alm_req(alm_req), .alm_mask(alm_mask), .alm_mode(alm_mode), .alm_ack(alm_ack),
        .alm_clr(alm_clr), .led_din(led_din), .led_vld(led_vld), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycleCount <= cycleCount + 1;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] modelDisplay();
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            w[4*i +: 4] = owned[i] ? 4'(almNib[i]) : 4'(hostNib[i]);
        end
        return w;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 8; i++) begin
            hostNib[i] = 0;
            almNib[i]  = 0;
            owned[i]   = 1'b0;
        end
        modelLed = '0;
    endtask

    // kind 0 = host write, 1 = alarm claim, 2 = alarm release; returns whether the display changes
    task automatic modelApply(input int kind, input logic [7:0] mask, input logic [31:0] mode,
                              output bit changed);
        logic [31:0] nw;
        for (int i = 0; i < 8; i++) begin
            if (kind == 2) begin
                owned[i] = 1'b0;
            end else if (mask[i]) begin
                if (kind == 0) begin
                    hostNib[i] = int'(mode[4*i +: 4]);
                end else begin
                    owned[i]  = 1'b1;
                    almNib[i] = int'(mode[4*i +: 4]);
                end
            end
        end
        nw       = modelDisplay();
        changed  = (nw !== modelLed);
        modelLed = nw;
    endtask

    task automatic applyStimulus(input int kind, input logic [7:0] mask, input logic [31:0] mode);
        bit   wasIdle;
        bit   expVld;
        int   waited;
        logic got;
        wasIdle = (busy === 1'b0) && (host_ack === 1'b0) && (alm_ack === 1'b0);
        modelApply(kind, mask, mode, expVld);
        if (kind == 0) begin
            host_mask = mask; host_mode = mode; host_req = 1'b1;
        end else begin
            alm_mask = mask; alm_mode = mode; alm_req = 1'b1;
        end
        waited = 0;
        got    = 1'b0;
        while (got !== 1'b1 && waited < BOUND) begin
            @(negedge clk);
            waited++;
            got = (kind == 0) ? host_ack : alm_ack;
        end
        if (kind == 0) begin
            host_req = 1'b0;
            checkOutput("hostAck", 32'(got), 32'd1);
        end else begin
            alm_req = 1'b0;
            checkOutput("almAck", 32'(got), 32'd1);
        end
        if (wasIdle) checkOutput("ackLatency", waited, 32'd1);
        checkOutput("singleAck", 32'(host_ack & alm_ack), 32'd0);
        checkOutput("vldWithAck", 32'(led_vld), 32'(expVld));
        checkOutput("ledDinAfterAck", led_din, modelLed);
    endtask

    task automatic pulseClr();
        bit expVld;
        int vlds;
        modelApply(2, 8'h00, 32'h0, expVld);
        vlds    = 0;
        alm_clr = 1'b1;
        @(negedge clk);
        alm_clr = 1'b0;
        if (led_vld === 1'b1) vlds++;
        for (int i = 0; i < H + 3; i++) begin
            @(negedge clk);
            if (led_vld === 1'b1) vlds++;
        end
        checkOutput("clrVldCount", vlds, 32'(expVld));
        checkOutput("ledDinAfterClr", led_din, modelLed);
    endtask

    task automatic waitIdle();
        int waited;
        waited = 0;
        while (busy !== 1'b0 && waited < BOUND) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("idleReached", 32'(busy), 32'd0);
    endtask

    task automatic waitVld(output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (led_vld !== 1'b1 && waited < 4 * HB);
    endtask

    task automatic reqHostRaw(input logic [7:0] mask, input logic [31:0] mode, output logic got);
        int waited;
        host_mask = mask; host_mode = mode; host_req = 1'b1;
        waited = 0;
        got    = 1'b0;
        while (got !== 1'b1 && waited < BOUND) begin
            @(negedge clk);
            waited++;
            got = host_ack;
        end
        host_req = 1'b0;
    endtask

    initial begin
        int          n;
        int          p;
        int          v1;
        int          kind;
        bit          e1;
        logic        got;
        logic [7:0]  rmask;
        logic [31:0] rmode;

        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("resetLedDin", led_din, 32'h0);
        checkOutput("resetLedVld", 32'(led_vld), 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetHostAck", 32'(host_ack), 32'd0);
        checkOutput("resetAlmAck", 32'(alm_ack), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef LED_SCHED_HEARTBEAT_EN
        waitVld(n);
        checkOutput("hbVldSeen", 32'(led_vld), 32'd1);
        checkOutput("hbFirstLed0", 32'(led_din[3:0]), 32'd1);
        v1 = cycleCount;
        for (int k = 1; k <= 4; k++) begin
            waitVld(n);
            checkOutput("hbPeriod", cycleCount - v1, HB);
            checkOutput("hbLed0", 32'(led_din[3:0]), (k % 2 == 1) ? 32'd0 : 32'd1);
            v1 = cycleCount;
        end
        reqHostRaw(8'h01, 32'h0000_0005, got);
        checkOutput("hbMask0Ack", 32'(got), 32'd1);
        checkOutput("hbMask0NoVld", 32'(led_vld), 32'd0);
        checkOutput("hbMask0Upper", 32'(led_din[31:4]), 32'd0);
        reqHostRaw(8'h03, 32'h0000_0035, got);
        checkOutput("hbMask1Ack", 32'(got), 32'd1);
        checkOutput("hbMask1Vld", 32'(led_vld), 32'd1);
        checkOutput("hbMask1Led", 32'(led_din[7:0]), 32'h31);
`else
        pulseClr();

        applyStimulus(0, 8'h01, 32'h0000_0001);
        checkOutput("firstLedDin", led_din, 32'h0000_0001);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checkOutput("busyLength", n, H + 1);

        applyStimulus(0, 8'hFF, 32'h2222_2222);
        v1 = cycleCount;
        applyStimulus(0, 8'hFF, 32'h0000_0000);
        checkOutput("backToBackSpacing", cycleCount - v1, H + 1);
        checkOutput("backToBackLedDin", led_din, 32'h0);

        waitIdle();
        applyStimulus(0, 8'hFF, 32'h1111_1111);
        applyStimulus(1, 8'h80, 32'h5000_0000);
        checkOutput("alarmOverride", led_din, 32'h5111_1111);
        applyStimulus(0, 8'h80, 32'h2000_0000);
        pulseClr();
        checkOutput("alarmRestore", led_din, 32'h2111_1111);

        waitIdle();
        applyStimulus(1, 8'h02, 32'h0000_0050);
        waitIdle();
        modelApply(2, 8'h00, 32'h0, e1);
        alm_mask = 8'h01; alm_mode = 32'h0000_0004; alm_req = 1'b1; alm_clr = 1'b1;
        @(negedge clk);
        alm_clr = 1'b0;
        checkOutput("clrFirstVld", 32'(led_vld), 32'(e1));
        checkOutput("clrFirstNoAck", 32'(alm_ack), 32'd0);
        checkOutput("clrFirstLedDin", led_din, modelLed);
        v1 = cycleCount;
        applyStimulus(1, 8'h01, 32'h0000_0004);
        checkOutput("clrThenAlmSpacing", cycleCount - v1, H + 1);
        checkOutput("clrThenAlmLedDin", led_din, 32'h2111_1114);
        applyStimulus(0, 8'h01, 32'h0000_0003);

        applyStimulus(0, 8'h0F, 32'h0000_3333);
        @(negedge clk);
        host_mask = 8'hFF; host_mode = 32'h0; host_req = 1'b1;
        @(negedge clk);
        host_req = 1'b0;
        n = 0;
        p = 0;
        for (int i = 0; i < H + 4; i++) begin
            @(negedge clk);
            if (host_ack === 1'b1) n++;
            if (led_vld === 1'b1) p++;
        end
        checkOutput("dropNoAck", n, 32'd0);
        checkOutput("dropNoVld", p, 32'd0);
        checkOutput("dropLedDin", led_din, modelLed);

        applyStimulus(0, 8'hFF, 32'h5555_5555);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncResetLedDin", led_din, 32'h0);
        checkOutput("asyncResetBusy", 32'(busy), 32'd0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 10)) @(negedge clk);
            kind  = int'($urandom_range(0, 9));
            rmask = 8'($urandom_range(0, 255));
            for (int j = 0; j < 8; j++) begin
                rmode[4*j +: 4] = 4'($urandom_range(0, 5));
            end
            if (kind < 2) begin
                pulseClr();
            end else if (kind < 6) begin
                applyStimulus(0, rmask, rmode);
            end else begin
                applyStimulus(1, rmask, rmode);
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
